// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; new divisors take effect at the period wrap or on sync_restart.
// Define CLKDIV_PHASE_EN to add per-channel phase offsets loaded into the counter on sync_restart.
module clk_div_multi #(
  parameter int               NCH         = 4,
  parameter int               CNT_W       = 28,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = 28'd255102,
  parameter int               CH_W        = 2
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_restart,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [CNT_W-1:0] wr_phase,
`endif
  output logic [NCH-1:0]   clock_out,
  output logic [NCH-1:0]   tick,
  output logic             cfg_err
);

  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

  logic [CNT_W-1:0] count   [NCH];
  logic [CNT_W-1:0] div_act [NCH];
  logic [CNT_W-1:0] div_shd [NCH];
`ifdef CLKDIV_PHASE_EN
  logic [CNT_W-1:0] phase_shd [NCH];
`endif

  logic wr_ok;

  always_comb begin
    wr_ok = wr_en && (wr_div >= CNT_W'(2)) && ({1'b0, wr_ch} < NCH_L);
`ifdef CLKDIV_PHASE_EN
    wr_ok = wr_ok && (wr_phase < wr_div);
`endif
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        count[i]   <= '0;
        div_act[i] <= DEFAULT_DIV;
        div_shd[i] <= DEFAULT_DIV;
`ifdef CLKDIV_PHASE_EN
        phase_shd[i] <= '0;
`endif
      end
      clock_out <= '0;
      tick      <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= wr_en && !wr_ok;
      for (int i = 0; i < NCH; i++) begin
        // Shadow update is independent of enable/restart; div_act samples the pre-write value.
        if (wr_ok && (wr_ch == CH_W'(i))) begin
          div_shd[i] <= wr_div;
`ifdef CLKDIV_PHASE_EN
          phase_shd[i] <= wr_phase;
`endif
        end

        if (sync_restart) begin
`ifdef CLKDIV_PHASE_EN
          count[i] <= phase_shd[i];
`else
          count[i] <= '0;
`endif
          div_act[i]   <= div_shd[i];
          clock_out[i] <= 1'b0;
          tick[i]      <= 1'b0;
        end else if (enable) begin
          clock_out[i] <= (count[i] < (div_act[i] >> 1));
          tick[i]      <= (count[i] == div_act[i] - CNT_W'(1));
          if (count[i] == div_act[i] - CNT_W'(1)) begin
            count[i]   <= '0;
            div_act[i] <= div_shd[i];
          end else begin
            count[i] <= count[i] + CNT_W'(1);
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (NCH=2, DEFAULT_DIV=4): the driver queues expected outputs,
// and a separate monitor compares them against the DUT after each sample event.
module tb_clk_div_multi;
  localparam int NCH   = 2;
  localparam int CNT_W = 8;
  localparam int CH_W  = 2;

  logic             clock_in     = 1'b0;
  logic             reset        = 1'b1;
  logic             enable       = 1'b0;
  logic             sync_restart = 1'b0;
  logic             wr_en        = 1'b0;
  logic [CH_W-1:0]  wr_ch        = '0;
  logic [CNT_W-1:0] wr_div       = '0;
  logic [NCH-1:0]   clock_out;
  logic [NCH-1:0]   tick;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;

  // Expected vector layout: {clock_out[1], clock_out[0], tick[1], tick[0], cfg_err}
  logic [4:0] exp_q[$];
  string      name_q[$];
  event       sample_ev;
  logic [4:0] mon_e, mon_a;
  string      mon_n;

  clk_div_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(8'd4), .CH_W(CH_W)
  ) dut (
    .clock_in(clock_in), .reset(reset), .enable(enable), .sync_restart(sync_restart),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .clock_out(clock_out), .tick(tick), .cfg_err(cfg_err)
  );

  always #5 clock_in = ~clock_in;

  always begin
    @(posedge clock_in);
    #1;
    -> sample_ev;
  end

  initial forever begin
    @(sample_ev);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {clock_out, tick, cfg_err};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got clk=%b tick=%b err=%b, want clk=%b tick=%b err=%b",
                 mon_n, mon_a[4:3], mon_a[2:1], mon_a[0], mon_e[4:3], mon_e[2:1], mon_e[0]);
      end
    end
  end

  // Expected {clk, tick} for position n within a square clock of period d counted from 0.
  function automatic logic [1:0] pat(int n, int d);
    int r;
    r = n % d;
    return {(r < d / 2), (r == d - 1)};
  endfunction

  function automatic logic [4:0] mk(int n0, int d0, int n1, int d1, logic err);
    logic [1:0] p0, p1;
    p0 = pat(n0, d0);
    p1 = pat(n1, d1);
    return {p1[1], p0[1], p1[0], p0[0], err};
  endfunction

  task automatic step(input logic en, input logic rs, input logic we, input logic [CH_W-1:0] ch,
                      input logic [CNT_W-1:0] dv, input logic [4:0] e, input string nm);
    enable       = en;
    sync_restart = rs;
    wr_en        = we;
    wr_ch        = ch;
    wr_div       = dv;
    @(posedge clock_in);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clock_in);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    exp_q.push_back(5'b00000);
    name_q.push_back("reset_initial");
    -> sample_ev;

    @(negedge clock_in);
    step(0, 0, 0, 0, 0, 5'b00000, "reset_held");
    step(1, 0, 0, 0, 0, 5'b00000, "reset_held_en");
    reset = 1'b0;

    for (int n = 0; n < 8; n++) step(1, 0, 0, 0, 0, mk(n, 4, n, 4, 1'b0), "default_div4");

    step(1, 0, 1, 2'd1, 8'd5, mk(8, 4, 8, 4, 1'b0), "wr_ch1_div5");
    step(1, 1, 0, 0, 0, 5'b00000, "restart_a");
    for (int n = 0; n < 10; n++) step(1, 0, 0, 0, 0, mk(n, 4, n, 5, 1'b0), "ch1_div5");

    // ch0 divisor 6 written while its count is 1: one more 4-cycle period, then period 6.
    step(1, 1, 0, 0, 0, 5'b00000, "restart_b");
    for (int m = 0; m < 16; m++)
      step(1, 0, (m == 1), 2'd0, 8'd6,
           mk((m < 4) ? m : m - 4, (m < 4) ? 4 : 6, m, 5, 1'b0), "ch0_div6_at_wrap");

    step(1, 1, 0, 0, 0, 5'b00000, "restart_c");
    for (int m = 0; m < 12; m++)
      step(1, 0, (m < 2), (m == 0) ? 2'd0 : 2'd3, (m == 0) ? 8'd1 : 8'd8,
           mk(m, 6, m, 5, (m < 2)), "rejected_writes");

    step(1, 1, 0, 0, 0, 5'b00000, "restart_d");
    for (int e = 0; e < 2; e++) step(1, 0, 0, 0, 0, mk(e, 6, e, 5, 1'b0), "freeze_pre");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 5'b11000, "freeze_hold");
    for (int e = 2; e < 13; e++) step(1, 0, 0, 0, 0, mk(e, 6, e, 5, 1'b0), "freeze_resume");

    // Asynchronous reset between edges while ch0 is high.
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(5'b00000);
    name_q.push_back("reset_async_mid");
    -> sample_ev;
    @(negedge clock_in);
    reset = 1'b0;
    for (int n = 0; n < 8; n++) step(1, 0, 0, 0, 0, mk(n, 4, n, 4, 1'b0), "after_reset");

    @(posedge clock_in);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
